regfile_bypass: RTL and testbench
=================================

# regfile_bypass

Parametrised successor to the core's 32x32 register file. It keeps two synchronous read ports and one write port. It adds configurable data width and depth, an optional hardwired-zero register, and optional same-cycle write-to-read bypass. It also adds an asynchronous reset followed by a hardware clear sequence, which zeroes every entry before the pipeline may use the file. It sits in the decode stage, between instruction decode and the ALU operand latches.

## Interface
Parameters:
- XLEN, 32, data width of every register and data port.
- ADDR_W, 5, register index width; depth NREGS = 2**ADDR_W.
- ZERO_REG, 1, when 1, index 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, when 1, a write and a read to the same index in the same cycle returns the new data.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- rs1i  input  ADDR_W  read port 1 index.
- rs2i  input  ADDR_W  read port 2 index.
- rdi  input  ADDR_W  write index.
- write_data  input  XLEN  write data.
- reg_write  input  1  write enable.
- read_data1  output  XLEN  registered read data, port 1.
- read_data2  output  XLEN  registered read data, port 2.
- busy  output  1  high while the clear sequence runs; the pipeline must stall.

## Operation
- Storage: an NREGS x XLEN array, plus a clear FSM and a clear index counter (ADDR_W bits).
- FSM states are CLEAR and RUN.
- Reset: rst high forces state CLEAR, clear_idx=0, busy=1, and read_data1=read_data2=0, asynchronously. Array contents are not reset directly.
- CLEAR state, each edge:
  - regs[clear_idx] <= 0, then clear_idx increments.
  - When clear_idx == NREGS-1, the state goes to RUN and busy goes to 0 on the same edge.
- In CLEAR, the reg_write and rd/rs inputs are ignored and both read outputs are held at 0.
- RUN state, each edge:
  - Write: if reg_write and not (ZERO_REG and rdi==0), then regs[rdi] <= write_data.
  - Read port k (identical for both):
    - If ZERO_REG and rsk==0, the port captures 0.
    - Otherwise, if BYPASS and reg_write and rdi==rsk, it captures write_data.
    - Otherwise, it captures regs[rsk] (the pre-edge value).
- Bypass never applies to index 0 when ZERO_REG=1.
- Both read ports may address the same index; both get the same value.
- RUN persists until the next rst.

## Timing
- Clear duration: NREGS rising edges after rst deasserts. busy is high for exactly those NREGS cycles (32 with defaults).
- Read latency: 1 cycle.
  - An index presented in cycle N appears on read_dataX after edge N.
  - The output holds until the next edge.
- Write latency: data written at edge N is visible to reads presented in cycle N+1.
  - With BYPASS=1, a read presented in cycle N also sees it.
  - With BYPASS=0, a read in cycle N returns the old value.
- Reset mid-clear or mid-run: clear_idx returns to 0 and the clear restarts from entry 0. Partial progress is discarded.
- rst asserted in the same cycle as a write: the write is lost.
- ADDR_W wrap: clear_idx stops at NREGS-1; there is no wrap into a second pass.

## Test plan
- Reset and clear: pulse rst, then release. busy must stay high for exactly 32 cycles and fall on the 32nd edge. All 32 indices must then read 0x00000000 on both ports.
- Write then read: write 0xDEADBEEF to x5, then read rs1i=5 and rs2i=5 on the next cycle. Both ports must show 0xDEADBEEF one cycle later.
- Bypass:
  - Write 0x12345678 to x7 while reading rs1i=7 in the same cycle. read_data1 must be 0x12345678 after that edge.
  - Repeat with BYPASS=0: the result must be the prior value of x7.
- Zero register:
  - Write 0xFFFFFFFF to x0 with a simultaneous read of x0; the result must be 0, and a later read of x0 must also be 0.
  - With ZERO_REG=0, x0 must store and return 0xFFFFFFFF.
- Writes during busy: assert reg_write rdi=3 data=0xA5A5A5A5 throughout the clear. x3 must read 0 afterwards and read_data1 must stay 0 while busy.
- Reset mid-clear: assert rst at clear cycle 10 and release it. busy must last a further full 32 cycles. Also run with XLEN=64, ADDR_W=4: busy must last 16 cycles, and a 64-bit pattern 0x0123456789ABCDEF must round-trip.

Source files
------------

// File: rtl/regfile_bypass.sv
// regfile_bypass: 2R1W register file with post-reset hardware clear, optional zero register and write-to-read bypass
module regfile_bypass #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1i,
    input  logic [ADDR_W-1:0] rs2i,
    input  logic [ADDR_W-1:0] rdi,
    input  logic [XLEN-1:0]   write_data,
    input  logic              reg_write,
    output logic [XLEN-1:0]   read_data1,
    output logic [XLEN-1:0]   read_data2,
    output logic              busy
);
    localparam int NREGS = 2 ** ADDR_W;
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] clear_idx;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] rd1_nxt, rd2_nxt;
    logic wr_en;
    function automatic logic [XLEN-1:0] rd_sel(input logic [ADDR_W-1:0] rs);
        return (ZERO_REG != 0 && rs == '0) ? '0 :
               (BYPASS != 0 && reg_write && rdi == rs) ? write_data : regs[rs];
    endfunction
    assign busy = state == CLEAR;
    assign wr_en = !busy && reg_write && !(ZERO_REG != 0 && rdi == '0);
    always_comb begin
        state_nxt = (state == CLEAR && &clear_idx) ? RUN : state;
        rd1_nxt = busy ? '0 : rd_sel(rs1i);
        rd2_nxt = busy ? '0 : rd_sel(rs2i);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLEAR;
            clear_idx  <= '0;
            read_data1 <= '0;
            read_data2 <= '0;
        end else begin
            state      <= state_nxt;
            clear_idx  <= (busy && !(&clear_idx)) ? clear_idx + 1'b1 : clear_idx;
            read_data1 <= rd1_nxt;
            read_data2 <= rd2_nxt;
        end
    end
    // Array has no reset; rst held over an edge still suppresses any write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) regs[clear_idx] <= '0;
            else if (wr_en) regs[rdi] <= write_data;
        end
    end
endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: scoreboard bench over default, no-bypass/no-zero and 64x16 variants
module tb_regfile_bypass;
    logic clk = 0;
    always #5 clk = ~clk;
    logic rst = 1, we = 0;
    logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
    logic [63:0] wd = 0;
    logic [31:0] a_r1, a_r2, b_r1, b_r2;
    logic [63:0] c_r1, c_r2;
    logic a_b, b_b, c_b;
    regfile_bypass u_a (.clk(clk), .rst(rst), .rs1i(rs1), .rs2i(rs2), .rdi(rd),
        .write_data(wd[31:0]), .reg_write(we), .read_data1(a_r1), .read_data2(a_r2), .busy(a_b));
    regfile_bypass #(.ZERO_REG(0), .BYPASS(0)) u_b (.clk(clk), .rst(rst), .rs1i(rs1), .rs2i(rs2), .rdi(rd),
        .write_data(wd[31:0]), .reg_write(we), .read_data1(b_r1), .read_data2(b_r2), .busy(b_b));
    regfile_bypass #(.XLEN(64), .ADDR_W(4)) u_c (.clk(clk), .rst(rst), .rs1i(rs1[3:0]), .rs2i(rs2[3:0]),
        .rdi(rd[3:0]), .write_data(wd), .reg_write(we), .read_data1(c_r1), .read_data2(c_r2), .busy(c_b));

    typedef struct packed {
        logic [2:0][63:0] r1;
        logic [2:0][63:0] r2;
        logic [2:0] b;
    } exp_t;
    exp_t q[$];
    int checks = 0, failures = 0;
    int nr[3] = '{32, 32, 16};
    int zr[3] = '{1, 0, 1};
    int bp[3] = '{1, 0, 1};
    logic [63:0] mem[3][32];
    int left[3] = '{0, 0, 0};

    function automatic logic [63:0] rdv(int k, int a, int d, logic [63:0] m);
        if (zr[k] != 0 && a == 0) return 64'd0;
        if (bp[k] != 0 && we && d == a) return wd & m;
        return mem[k][a];
    endfunction

    task automatic step();
        exp_t e;
        logic [63:0] m;
        int a1, a2, ad;
        for (int k = 0; k < 3; k++) begin
            m  = (k == 2) ? '1 : 64'hFFFF_FFFF;
            a1 = int'(rs1) & (nr[k] - 1);
            a2 = int'(rs2) & (nr[k] - 1);
            ad = int'(rd) & (nr[k] - 1);
            if (rst) begin
                e.r1[k] = 0; e.r2[k] = 0; e.b[k] = 1; left[k] = nr[k];
            end else if (left[k] > 0) begin
                mem[k][nr[k] - left[k]] = 0;
                left[k]--;
                e.r1[k] = 0; e.r2[k] = 0; e.b[k] = left[k] > 0;
            end else begin
                e.r1[k] = rdv(k, a1, ad, m);
                e.r2[k] = rdv(k, a2, ad, m);
                e.b[k] = 0;
                if (we && !(zr[k] != 0 && ad == 0)) mem[k][ad] = wd & m;
            end
        end
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rd1", 0, {32'd0, a_r1}, e.r1[0]);
            chk("rd2", 0, {32'd0, a_r2}, e.r2[0]);
            chk("busy", 0, {63'd0, a_b}, {63'd0, e.b[0]});
            chk("rd1", 1, {32'd0, b_r1}, e.r1[1]);
            chk("rd2", 1, {32'd0, b_r2}, e.r2[1]);
            chk("busy", 1, {63'd0, b_b}, {63'd0, e.b[1]});
            chk("rd1", 2, c_r1, e.r1[2]);
            chk("rd2", 2, c_r2, e.r2[2]);
            chk("busy", 2, {63'd0, c_b}, {63'd0, e.b[2]});
        end
    end

    initial begin
        #2;
        step(); step();
        rst = 0; we = 1; rd = 3; wd = 64'hA5A5_A5A5_A5A5_A5A5; rs1 = 3; rs2 = 3;
        repeat (10) step();
        rst = 1; step();
        rst = 0;
        repeat (32) step();
        we = 0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i); step();
        end
        we = 1; rd = 5; wd = 64'h0000_0000_DEAD_BEEF; rs1 = 1; rs2 = 2; step();
        we = 0; rs1 = 5; rs2 = 5; step(); step();
        we = 1; rd = 7; wd = 64'h0000_0000_1234_5678; rs1 = 7; rs2 = 2; step();
        we = 0; step();
        we = 1; rd = 0; wd = '1; rs1 = 0; rs2 = 0; step();
        we = 0; step();
        we = 1; rd = 9; wd = 64'h0123_4567_89AB_CDEF; rs1 = 9; rs2 = 3; step();
        we = 0; rs2 = 9; step();
        for (int i = 0; i < 400; i++) begin
            rst = $urandom_range(149) == 0;
            we = $urandom_range(1);
            rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
            if ($urandom_range(3) == 0) rs1 = rd;
            wd = {$urandom, $urandom};
            step();
        end
        rst = 0; we = 0;
        repeat (3) step();
        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
